upcounter: RTL and testbench

UPCOUNTER -- requirements
Module: upcounter

---
 rtl/upcounter.sv | 99 +++++++++
 tb/tb_upcounter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/upcounter.sv
// ----------------------------------------------------------------------------
// upcounter
//
// Purpose:
//    Parameterised unsigned up-counter with a programmable terminal count.
//    When the count reaches MAX_VALUE it either wraps back to zero (and
//    raises a one-cycle wrap pulse) or saturates at MAX_VALUE, depending on
//    SATURATE. All outputs are registered.
//
// Parameters:
//    SIZE       counter width in bits (1..32), first so #(N) sets the width
//    MAX_VALUE  terminal count, 0..2**SIZE-1 (default all ones)
//    SATURATE   0 = wrap to zero after MAX_VALUE, 1 = hold at MAX_VALUE
//
// Ports:
//    clock      sole clock, rising edge
//    reset      asynchronous, active-low reset
//    enable     count enable, sampled on the rising edge
//    oResult    current count value
//    oTerminal  high while oResult == MAX_VALUE
//    oWrap      one-cycle pulse in the cycle after a wrap to zero
// ----------------------------------------------------------------------------
module upcounter #(
   parameter int unsigned     SIZE      = 16,
   parameter logic [SIZE-1:0] MAX_VALUE = {SIZE{1'b1}},
   parameter bit              SATURATE  = 1'b0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   output logic [SIZE-1:0] oResult,
   output logic            oTerminal,
   output logic            oWrap
);

   localparam logic [SIZE-1:0] ONE           = SIZE'(1);
   localparam logic            TERM_AT_RESET = (MAX_VALUE == '0);

   logic [SIZE-1:0] r_count;
   logic            r_terminal;
   logic            r_wrap;
   logic            r_runEn;

   logic            w_atMax;
   logic [SIZE-1:0] w_nextCount;
   logic            w_nextTerminal;
   logic            w_nextWrap;

   // Reset release is retimed through one flop: assertion clears it
   // immediately, and it only goes high on a clock edge. Counting is gated
   // on it, so the first increment always lands one edge after release
   // instead of on an edge that may coincide with the release itself.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_runEn <= 1'b0;
      end else begin
         r_runEn <= 1'b1;
      end
   end

   // Next-count selection. The terminal flag is computed from the next
   // count so that it can be registered alongside it and still match the
   // count in the same cycle, without any path from enable to the output.
   always_comb begin
      w_atMax        = (r_count == MAX_VALUE);
      w_nextCount    = r_count;
      w_nextWrap     = 1'b0;
      if (r_runEn && enable) begin
         if (w_atMax) begin
            if (!SATURATE) begin
               w_nextCount = '0;
               w_nextWrap  = 1'b1;
            end
         end else begin
            w_nextCount = r_count + ONE;
         end
      end
      w_nextTerminal = (w_nextCount == MAX_VALUE);
   end

   // Output registers. Reset forces the idle values straight away, which
   // also drops any wrap pulse that was about to be shown.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_terminal <= TERM_AT_RESET;
         r_wrap     <= 1'b0;
      end else begin
         r_count    <= w_nextCount;
         r_terminal <= w_nextTerminal;
         r_wrap     <= w_nextWrap;
      end
   end

   assign oResult   = r_count;
   assign oTerminal = r_terminal;
   assign oWrap     = r_wrap;

endmodule

// File: tb/tb_upcounter.sv
// ----------------------------------------------------------------------------
// tb_upcounter
//
// Drives five upcounter configurations in parallel from one shared stimulus
// stream. The stimulus side keeps a reference count per configuration and
// queues the expected outputs for each cycle; a monitor on the falling edge
// pops each entry and compares it against all instances.
//
//    dut0  SIZE=11, defaults (MAX 2047, wrap)
//    dut1  #(4) positional, defaults (MAX 15, wrap)
//    dut2  SIZE=4, SATURATE=1 (MAX 15, hold)
//    dut3  SIZE=11, MAX_VALUE=520 (wrap)
//    dut4  SIZE=4, MAX_VALUE=0 (wrap every enabled cycle)
// ----------------------------------------------------------------------------
module tb_upcounter;

   localparam int NDUT = 5;

   logic clock  = 1'b0;
   logic reset  = 1'b0;
   logic enable = 1'b0;

   logic [10:0] res0;
   logic [3:0]  res1;
   logic [3:0]  res2;
   logic [10:0] res3;
   logic [3:0]  res4;
   logic [NDUT-1:0] actTerm;
   logic [NDUT-1:0] actWrap;
   logic [NDUT-1:0][31:0] actRes;

   typedef struct packed {
      logic [NDUT-1:0][31:0] res;
      logic [NDUT-1:0]       term;
      logic [NDUT-1:0]       wrap;
   } expT;

   expT sbQ[$];
   expT monExp;

   int checks = 0;
   int errors = 0;

   int unsigned mCount [NDUT];
   bit          mWrap  [NDUT];
   bit          mRun;

   always #5 clock = ~clock;

   upcounter #(.SIZE(11)) dut0 (
      .clock(clock), .reset(reset), .enable(enable),
      .oResult(res0), .oTerminal(actTerm[0]), .oWrap(actWrap[0]));

   upcounter #(4) dut1 (
      .clock(clock), .reset(reset), .enable(enable),
      .oResult(res1), .oTerminal(actTerm[1]), .oWrap(actWrap[1]));

   upcounter #(.SIZE(4), .SATURATE(1'b1)) dut2 (
      .clock(clock), .reset(reset), .enable(enable),
      .oResult(res2), .oTerminal(actTerm[2]), .oWrap(actWrap[2]));

   upcounter #(.SIZE(11), .MAX_VALUE(11'd520)) dut3 (
      .clock(clock), .reset(reset), .enable(enable),
      .oResult(res3), .oTerminal(actTerm[3]), .oWrap(actWrap[3]));

   upcounter #(.SIZE(4), .MAX_VALUE(4'd0)) dut4 (
      .clock(clock), .reset(reset), .enable(enable),
      .oResult(res4), .oTerminal(actTerm[4]), .oWrap(actWrap[4]));

   assign actRes[0] = 32'(res0);
   assign actRes[1] = 32'(res1);
   assign actRes[2] = 32'(res2);
   assign actRes[3] = 32'(res3);
   assign actRes[4] = 32'(res4);

   // Terminal value and overflow behaviour of each configuration
   function automatic int unsigned maxOf(input int k);
      case (k)
         0:       maxOf = 2047;
         1:       maxOf = 15;
         2:       maxOf = 15;
         3:       maxOf = 520;
         default: maxOf = 0;
      endcase
   endfunction

   function automatic bit satOf(input int k);
      satOf = (k == 2);
   endfunction

   // Reference behaviour for one rising edge, using the inputs that were
   // held across that edge. The first edge after reset release only arms
   // counting; it never changes the count.
   task automatic modelEdge();
      for (int k = 0; k < NDUT; k++) begin
         if (!reset) begin
            mCount[k] = 0;
            mWrap[k]  = 1'b0;
         end else if (!mRun || !enable) begin
            mWrap[k]  = 1'b0;
         end else if (mCount[k] < maxOf(k)) begin
            mCount[k] = mCount[k] + 1;
            mWrap[k]  = 1'b0;
         end else if (satOf(k)) begin
            mWrap[k]  = 1'b0;
         end else begin
            mCount[k] = 0;
            mWrap[k]  = 1'b1;
         end
      end
      mRun = (reset == 1'b1);
   endtask

   task automatic modelReset();
      for (int k = 0; k < NDUT; k++) begin
         mCount[k] = 0;
         mWrap[k]  = 1'b0;
      end
      mRun = 1'b0;
   endtask

   task automatic pushExp();
      expT e;
      for (int k = 0; k < NDUT; k++) begin
         e.res[k]  = mCount[k];
         e.term[k] = (mCount[k] == maxOf(k));
         e.wrap[k] = mWrap[k];
      end
      sbQ.push_back(e);
   endtask

   // One clock cycle: let the edge happen, then change inputs 2ns later
   // and queue what the outputs must show at the following falling edge.
   task automatic applyStimulus(input logic en, input logic rstN);
      @(posedge clock);
      modelEdge();
      #2;
      reset  = rstN;
      enable = en;
      if (!rstN) modelReset();
      pushExp();
   endtask

   // Reset pulse entirely between two rising edges; the falling-edge check
   // lands while reset is low, so the outputs must already be cleared.
   task automatic pulseReset(input logic en);
      @(posedge clock);
      modelEdge();
      #2;
      reset  = 1'b0;
      enable = en;
      modelReset();
      pushExp();
      #4;
      reset  = 1'b1;
   endtask

   task automatic checkOutput(input string name, input int k,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d at %0t: got %0d expected %0d",
                  name, k, $time, act, exp);
      end
   endtask

   // Monitor: every falling edge with a queued expectation is compared
   always @(negedge clock) begin
      if (sbQ.size() != 0) begin
         monExp = sbQ.pop_front();
         for (int k = 0; k < NDUT; k++) begin
            checkOutput("oResult",   k, actRes[k],          monExp.res[k]);
            checkOutput("oTerminal", k, 32'(actTerm[k]),    32'(monExp.term[k]));
            checkOutput("oWrap",     k, 32'(actWrap[k]),    32'(monExp.wrap[k]));
         end
      end
   end

   initial begin
      modelReset();
      $display("[TB] start");

      // Held in reset: count 0, terminal only where MAX_VALUE is 0
      repeat (3) applyStimulus(1'b0, 1'b0);

      // Release with enable high and run long enough for dut0 to pass 799,
      // dut1 to wrap many times, dut2 to sit at 15 and dut3 to wrap at 520
      applyStimulus(1'b1, 1'b1);
      repeat (810) applyStimulus(1'b1, 1'b1);

      // Restart from reset, count to 5, hold for three edges, resume
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1);
      repeat (5) applyStimulus(1'b1, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b1);
      repeat (4) applyStimulus(1'b1, 1'b1);

      // Around count 9, pulse reset between edges and restart from 0
      pulseReset(1'b1);
      repeat (6) applyStimulus(1'b1, 1'b1);

      // Irregular enable pattern, including runs across the wraps
      repeat (200) applyStimulus(1'($urandom_range(0, 1)), 1'b1);

      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d queued entries expected 0", sbQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
